// File: rtl/vscale_htif_tohost_poller_pkg.sv
// Shared types and constants for the host-side HTIF tohost poller.
package vscale_htif_tohost_poller_pkg;

  localparam int CSR_ADDR_WIDTH = 12;
  localparam int HTIF_PCR_WIDTH = 64;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_TO_HOST = 12'h780;
  localparam logic [HTIF_PCR_WIDTH-1:0] HTIF_TOHOST_PASS = 64'd1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START_WAIT = 3'd1,
    ST_RD_REQ     = 3'd2,
    ST_RD_RESP    = 3'd3,
    ST_GAP        = 3'd4,
    ST_WR_REQ     = 3'd5,
    ST_WR_RESP    = 3'd6,
    ST_DONE       = 3'd7
  } poller_state_t;

  // A nonzero tohost other than the pass value carries the failing test number in its upper bits.
  function automatic logic [HTIF_PCR_WIDTH-2:0] decode_fail_code(input logic [HTIF_PCR_WIDTH-1:0] value);
    if (value == HTIF_TOHOST_PASS) begin
      return '0;
    end
    return value[HTIF_PCR_WIDTH-1:1];
  endfunction

endpackage

// File: rtl/vscale_htif_delay_cnt.sv
// Loadable down-counter with a zero flag, used for the start delay and the inter-poll gap.
module vscale_htif_delay_cnt
  import vscale_htif_tohost_poller_pkg::*;
#(
  parameter int                CNT_W       = 32,
  parameter logic [CNT_W-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  assign zero = (count == '0);

  // Load takes priority over decrement; the count parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/vscale_htif_tohost_poller.sv
// Host-side HTIF agent: polls tohost over the PCR channel, acknowledges a result by writing 0,
// and reports pass / fail code / timeout to the simulation harness.
module vscale_htif_tohost_poller
  import vscale_htif_tohost_poller_pkg::*;
#(
  parameter int START_DELAY   = 64,
  parameter int POLL_INTERVAL = 16,
  parameter int MAX_POLLS     = 100000,
  parameter int CNT_W         = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  output logic                        htif_pcr_req_valid,
  input  logic                        htif_pcr_req_ready,
  output logic                        htif_pcr_req_rw,
  output logic [CSR_ADDR_WIDTH-1:0]   htif_pcr_req_addr,
  output logic [HTIF_PCR_WIDTH-1:0]   htif_pcr_req_data,
  input  logic                        htif_pcr_resp_valid,
  output logic                        htif_pcr_resp_ready,
  input  logic [HTIF_PCR_WIDTH-1:0]   htif_pcr_resp_data,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic [HTIF_PCR_WIDTH-2:0]   fail_code,
  output logic [CNT_W-1:0]            poll_count
);

  // The counter exits on zero, so it is loaded with one less than the cycles to spend in the state.
  localparam logic [CNT_W-1:0] START_LOAD = (START_DELAY > 0) ? CNT_W'(START_DELAY - 1) : '0;
  localparam logic [CNT_W-1:0] GAP_LOAD   = (POLL_INTERVAL > 0) ? CNT_W'(POLL_INTERVAL - 1) : '0;
  localparam logic [CNT_W:0]   POLL_LIMIT = (CNT_W+1)'(MAX_POLLS);

  poller_state_t state;
  poller_state_t next_state;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_value;
  logic             cnt_dec;
  logic             cnt_zero;

  logic req_fire;
  logic resp_fire;
  logic rd_resp_fire;
  logic read_zero;
  logic poll_limit;

  logic req_valid_next;
  logic req_rw_next;
  logic resp_ready_next;
  logic done_next;

  assign htif_pcr_req_addr = CSR_ADDR_TO_HOST;
  assign htif_pcr_req_data = '0;

  assign req_fire     = htif_pcr_req_valid && htif_pcr_req_ready;
  assign resp_fire    = htif_pcr_resp_valid && htif_pcr_resp_ready;
  assign rd_resp_fire = (state == ST_RD_RESP) && resp_fire;
  assign read_zero    = (htif_pcr_resp_data == '0);
  assign poll_limit   = ({1'b0, poll_count} + (CNT_W+1)'(1)) >= POLL_LIMIT;

  vscale_htif_delay_cnt #(
    .CNT_W       (CNT_W),
    .RESET_VALUE (START_LOAD)
  ) u_delay_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection; each request state waits for its handshake, each response state for resp_valid.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (enable) next_state = ST_START_WAIT;
      end
      ST_START_WAIT: begin
        if (cnt_zero) next_state = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        if (req_fire) next_state = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (resp_fire) begin
          if (!read_zero) begin
            next_state = ST_WR_REQ;
          end else if (poll_limit) begin
            next_state = ST_DONE;
          end else if (POLL_INTERVAL == 0) begin
            next_state = ST_RD_REQ;
          end else begin
            next_state = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (!enable) begin
          next_state = ST_IDLE;
        end else if (cnt_zero) begin
          next_state = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        if (req_fire) next_state = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (resp_fire) next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = ST_DONE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the strobes register in step with the state itself.
  always_comb begin
    req_valid_next  = (next_state == ST_RD_REQ) || (next_state == ST_WR_REQ);
    req_rw_next     = (next_state == ST_WR_REQ);
    resp_ready_next = (next_state == ST_RD_RESP) || (next_state == ST_WR_RESP);
    done_next       = (next_state == ST_DONE);
    cnt_load        = 1'b0;
    cnt_load_value  = START_LOAD;
    cnt_dec         = 1'b0;
    if ((next_state == ST_START_WAIT) && (state != ST_START_WAIT)) begin
      cnt_load       = 1'b1;
      cnt_load_value = START_LOAD;
    end else if ((next_state == ST_GAP) && (state != ST_GAP)) begin
      cnt_load       = 1'b1;
      cnt_load_value = GAP_LOAD;
    end else if ((state == ST_START_WAIT) || (state == ST_GAP)) begin
      cnt_dec = 1'b1;
    end
  end

  // Registered handshake strobes plus the sticky result flags and saturating poll counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      htif_pcr_req_valid  <= 1'b0;
      htif_pcr_req_rw     <= 1'b0;
      htif_pcr_resp_ready <= 1'b0;
      done                <= 1'b0;
      pass                <= 1'b0;
      timeout             <= 1'b0;
      fail_code           <= '0;
      poll_count          <= '0;
    end else begin
      htif_pcr_req_valid  <= req_valid_next;
      htif_pcr_req_rw     <= req_rw_next;
      htif_pcr_resp_ready <= resp_ready_next;
      done                <= done_next;
      if (rd_resp_fire) begin
        if (poll_count != '1) begin
          poll_count <= poll_count + CNT_W'(1);
        end
        if (!read_zero) begin
          pass      <= (htif_pcr_resp_data == HTIF_TOHOST_PASS);
          fail_code <= decode_fail_code(htif_pcr_resp_data);
        end else if (poll_limit) begin
          timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vscale_htif_tohost_poller.sv
// Self-checking bench: a randomized PCR responder plus a list-based model of the expected test outcome.
module tb_vscale_htif_tohost_poller;
  import vscale_htif_tohost_poller_pkg::*;

  localparam int TB_START_DELAY   = 5;
  localparam int TB_POLL_INTERVAL = 3;
  localparam int TB_MAX_POLLS     = 6;
  localparam int TB_CNT_W         = 16;

  logic                      clk;
  logic                      reset;
  logic                      enable;
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_rw;
  logic [CSR_ADDR_WIDTH-1:0] req_addr;
  logic [HTIF_PCR_WIDTH-1:0] req_data;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [HTIF_PCR_WIDTH-1:0] resp_data;
  logic                      done;
  logic                      pass;
  logic                      timeout;
  logic [HTIF_PCR_WIDTH-2:0] fail_code;
  logic [TB_CNT_W-1:0]       poll_count;

  vscale_htif_tohost_poller #(
    .START_DELAY   (TB_START_DELAY),
    .POLL_INTERVAL (TB_POLL_INTERVAL),
    .MAX_POLLS     (TB_MAX_POLLS),
    .CNT_W         (TB_CNT_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .htif_pcr_req_valid  (req_valid),
    .htif_pcr_req_ready  (req_ready),
    .htif_pcr_req_rw     (req_rw),
    .htif_pcr_req_addr   (req_addr),
    .htif_pcr_req_data   (req_data),
    .htif_pcr_resp_valid (resp_valid),
    .htif_pcr_resp_ready (resp_ready),
    .htif_pcr_resp_data  (resp_data),
    .done                (done),
    .pass                (pass),
    .timeout             (timeout),
    .fail_code           (fail_code),
    .poll_count          (poll_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Responder configuration, written only by the main sequence.
  logic [HTIF_PCR_WIDTH-1:0] rd_q[$];
  int rmin = 0, rmax = 0, pmin = 0, pmax = 0;
  bit stray_en = 0, hold_resp = 0, force_stray = 0;

  // Responder bookkeeping, written only by the responder.
  bit in_req = 0, pending = 0, resp_is_read = 0;
  int ready_wait = 0, resp_wait = 0;
  int reads = 0, writes = 0, rd_idx = 0;
  int read_cycle[$];
  bit wr_bad = 0, addr_bad = 0, stable_bad = 0, dropped = 0;
  logic [76:0] snap;

  // Model outputs.
  int exp_reads, exp_writes;
  logic [63:0] exp_pass, exp_timeout, exp_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] readValue(input int idx);
    if (idx < rd_q.size()) return rd_q[idx];
    return 64'd0;
  endfunction

  // The outcome follows from the first nonzero value among the first MAX_POLLS read results.
  task automatic computeExpected();
    exp_reads = TB_MAX_POLLS; exp_writes = 0;
    exp_pass = 0; exp_timeout = 1; exp_fail = 0;
    for (int k = 0; k < TB_MAX_POLLS; k++) begin
      logic [63:0] v;
      v = readValue(k);
      if (v != 0) begin
        exp_reads = k + 1; exp_writes = 1; exp_timeout = 0;
        exp_pass = (v == 64'd1) ? 64'd1 : 64'd0;
        exp_fail = (v == 64'd1) ? 64'd0 : (v >> 1);
        break;
      end
    end
  endtask

  // Responder acting as the vscale side of the PCR channel; samples and drives on the falling edge.
  initial begin
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        in_req = 0; pending = 0; reads = 0; writes = 0; rd_idx = 0; read_cycle.delete();
        wr_bad = 0; addr_bad = 0; stable_bad = 0; dropped = 0;
        req_ready = 1'b0; resp_valid = force_stray; resp_data = 64'd1;
      end else begin
        if (force_stray) begin
          resp_valid = 1'b1; resp_data = 64'd1;
        end else if (pending) begin
          if (hold_resp) begin
            resp_valid = 1'b0;
          end else if (resp_wait > 0) begin
            resp_valid = 1'b0; resp_wait--;
          end else begin
            resp_valid = 1'b1;
            resp_data = resp_is_read ? readValue(rd_idx) : {$urandom, $urandom};
            if (resp_ready === 1'b1) begin
              pending = 0;
              if (resp_is_read) rd_idx++;
            end
          end
        end else begin
          resp_valid = stray_en && ($urandom_range(0, 3) == 0);
          resp_data = 64'd1;
        end
        if (req_valid === 1'b1) begin
          if (!in_req) begin
            in_req = 1; ready_wait = $urandom_range(rmax, rmin);
            snap = {req_rw, req_addr, req_data};
          end else if ({req_rw, req_addr, req_data} !== snap) begin
            stable_bad = 1;
          end
          if (ready_wait > 0) begin
            req_ready = 1'b0; ready_wait--;
          end else begin
            req_ready = 1'b1; in_req = 0; pending = 1;
            resp_wait = $urandom_range(pmax, pmin); resp_is_read = !req_rw;
            if (req_addr !== CSR_ADDR_TO_HOST) addr_bad = 1;
            if (req_rw === 1'b1) begin
              writes++;
              if (req_data !== '0) wr_bad = 1;
            end else begin
              reads++; read_cycle.push_back(cyc);
            end
          end
        end else begin
          if (in_req) dropped = 1;
          in_req = 0; req_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, req_valid, 0);
    checkOutput({tag, "_rw"}, req_rw, 0);
    checkOutput({tag, "_data"}, req_data, 0);
    checkOutput({tag, "_rready"}, resp_ready, 0);
    checkOutput({tag, "_flags"}, {done, pass, timeout}, 0);
    checkOutput({tag, "_fail"}, fail_code, 0);
    checkOutput({tag, "_polls"}, poll_count, 0);
  endtask

  task automatic doReset();
    reset = 1'b1; enable = 1'b0;
    tick(3);
    checkResetState("reset");
    checkOutput("reset_addr", req_addr, CSR_ADDR_TO_HOST);
    reset = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick(1); n++;
    end
    checkOutput("done_reached", done === 1'b1, 1);
  endtask

  task automatic checkResult();
    computeExpected();
    checkOutput("done", done, 1);
    checkOutput("pass", pass, exp_pass);
    checkOutput("timeout", timeout, exp_timeout);
    checkOutput("fail_code", fail_code, exp_fail);
    checkOutput("poll_count", poll_count, exp_reads);
    checkOutput("reads", reads, exp_reads);
    checkOutput("writes", writes, exp_writes);
    checkOutput("handshake_flags", {wr_bad, addr_bad, stable_bad, dropped}, 0);
  endtask

  task automatic applyStimulus(input string name, input int r_lo, input int r_hi,
                               input int p_lo, input int p_hi, input bit stray);
    int en_cyc;
    $display("[TB] scenario %s", name);
    rmin = r_lo; rmax = r_hi; pmin = p_lo; pmax = p_hi; stray_en = stray;
    doReset();
    tick(1);
    enable = 1'b1; en_cyc = cyc;
    waitDone(4000);
    tick(2);
    checkResult();
    if (reads > 0) checkOutput("start_delay", (read_cycle[0] - en_cyc) >= TB_START_DELAY, 1);
    if (r_hi == 0 && p_hi == 0 && reads >= 2)
      checkOutput("poll_spacing", (read_cycle[1] - read_cycle[0]) >= TB_POLL_INTERVAL + 2, 1);
    tick(10);
    checkOutput("done_absorbing", {reads, writes}, {exp_reads, exp_writes});
    checkOutput("done_quiet", {req_valid, resp_ready}, 0);
    enable = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0;

    rd_q = '{64'd0, 64'd0, 64'd1};
    applyStimulus("pass_third", 0, 0, 0, 0, 0);

    rd_q = '{64'h15};
    applyStimulus("fail_first", 0, 0, 0, 0, 0);

    rd_q.delete();
    applyStimulus("timeout", 0, 0, 0, 0, 1);

    rd_q = '{64'd0, 64'h2A};
    applyStimulus("stalls", 5, 5, 7, 7, 1);

    for (int it = 0; it < 8; it++) begin
      rd_q.delete();
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) begin
        int r;
        r = $urandom_range(0, 5);
        if (r < 3) rd_q.push_back(64'd0);
        else if (r == 3) rd_q.push_back(64'd1);
        else rd_q.push_back({$urandom, $urandom});
      end
      applyStimulus("random", 0, 4, 0, 4, 1);
    end

    // Reset while a read response is outstanding, with a response-looking strobe around the reset.
    $display("[TB] scenario reset_in_resp");
    rd_q = '{64'd1}; rmin = 0; rmax = 0; pmin = 0; pmax = 0; stray_en = 0;
    doReset();
    hold_resp = 1; enable = 1'b1;
    n = 0;
    while (resp_ready !== 1'b1 && n < 200) begin tick(1); n++; end
    checkOutput("reached_rd_resp", resp_ready === 1'b1, 1);
    force_stray = 1; reset = 1'b1;
    tick(1);
    checkResetState("midreset");
    reset = 1'b0; enable = 1'b0;
    tick(5);
    checkResetState("after_stray");
    force_stray = 0; hold_resp = 0;

    // Dropping enable during the gap parks the poller in IDLE until enable returns.
    $display("[TB] scenario enable_gap");
    rd_q.delete();
    doReset();
    enable = 1'b1;
    n = 0;
    while (!(reads == 1 && !pending && resp_ready === 1'b0) && n < 200) begin tick(1); n++; end
    checkOutput("reached_gap", reads == 1 && !pending, 1);
    enable = 1'b0;
    tick(40);
    checkOutput("idle_reads", reads, 1);
    checkOutput("idle_quiet", {req_valid, resp_ready, done}, 0);
    enable = 1'b1;
    waitDone(4000);
    tick(2);
    checkResult();
    enable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
